// File: rtl/onewire_slave_pkg.sv
// Shared definitions for the 1-wire responder: FSM state encoding and
// default bus timing in 32.768 MHz clock cycles.
package onewire_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SLOT  = 3'd1,
    ST_RESET = 3'd2,
    ST_PDLY  = 3'd3,
    ST_PRES  = 3'd4
  } ow_state_e;

  localparam int unsigned T_SMP_DEF  = 983;    // 30 us
  localparam int unsigned T_RST_DEF  = 13107;  // 400 us
  localparam int unsigned T_PDLY_DEF = 983;    // 30 us
  localparam int unsigned T_PRS_DEF  = 3932;   // 120 us
  localparam int unsigned TW_DEF     = 16;

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for the raw 1-wire level plus a falling-edge detect
// on the synchronized signal. Flops reset high to match an idle bus.
module onewire_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/onewire_slave.sv
// 1-wire bus responder: detects bus resets and answers with presence,
// samples write slots into bytes and pulls the line low for 0-bits of a tx byte.
module onewire_slave
  import onewire_slave_pkg::*;
#(
  parameter int unsigned T_SMP  = T_SMP_DEF,
  parameter int unsigned T_RST  = T_RST_DEF,
  parameter int unsigned T_PDLY = T_PDLY_DEF,
  parameter int unsigned T_PRS  = T_PRS_DEF,
  parameter int unsigned TW     = TW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       owr_i,
  output logic       owr_e,
  input  logic [7:0] tx_dat,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  output logic       bus_rst,
  output logic [2:0] state_o
);

  localparam logic [TW-1:0] SMP_LAST  = TW'(T_SMP - 1);
  localparam logic [TW-1:0] SMP_DONE  = TW'(T_SMP);
  localparam logic [TW-1:0] RST_LAST  = TW'(T_RST - 1);
  localparam logic [TW-1:0] PDLY_LAST = TW'(T_PDLY - 1);
  localparam logic [TW-1:0] PRS_LAST  = TW'(T_PRS - 1);
  localparam logic [TW-1:0] TMR_MAX   = {TW{1'b1}};

  logic line;
  logic fall;

  onewire_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(owr_i),
    .sync_o (line),
    .fall_o (fall)
  );

  ow_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          armed_q, armed_d;
  logic [7:0]    txsh_q, txsh_d;
  logic [7:0]    rxsh_q, rxsh_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    rx_dat_q, rx_dat_d;
  logic          rx_vld_q, rx_vld_d;
  logic          bus_rst_q, bus_rst_d;
  logic          owr_e_q, owr_e_d;
  logic [1:0]    mask_q, mask_d;

  logic       fall_ok;
  logic       xfer;
  logic       sample_now;
  logic       past_sample;
  logic       rst_hit;
  logic       drive_bit;
  logic [7:0] rx_next;

  // tx handshake: a byte moves when tx_vld && tx_rdy are both high at a
  // rising clk edge; tx_dat must be stable while tx_vld is high.
  assign tx_rdy = !armed_q && (bcnt_q == 3'd0) && (state_q == ST_IDLE);
  assign xfer   = tx_vld && tx_rdy;

  // Our own presence pulse comes back through the synchronizer; ignore it.
  assign fall_ok     = fall && (state_q != ST_PRES) && (mask_q == 2'd0);
  assign rst_hit     = (state_q == ST_SLOT) && (timer_q == RST_LAST) && !line;
  assign sample_now  = (state_q == ST_SLOT) && (timer_q == SMP_LAST) && !rst_hit;
  assign past_sample = timer_q >= SMP_DONE;
  assign drive_bit   = xfer ? !tx_dat[0] : (armed_q && !txsh_q[0]);
  assign rx_next     = {line, rxsh_q[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fall_ok) state_d = ST_SLOT;
      ST_SLOT: begin
        if (rst_hit) state_d = ST_RESET;
        else if (past_sample && line) state_d = ST_IDLE;
      end
      ST_RESET: if (line) state_d = ST_PDLY;
      ST_PDLY:  if (timer_q == PDLY_LAST) state_d = ST_PRES;
      ST_PRES:  if (timer_q == PRS_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_d   = (state_d != state_q) ? '0 :
                (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
    armed_d   = armed_q;
    txsh_d    = txsh_q;
    rxsh_d    = rxsh_q;
    bcnt_d    = bcnt_q;
    rx_dat_d  = rx_dat_q;
    rx_vld_d  = 1'b0;
    bus_rst_d = 1'b0;
    mask_d    = (mask_q != 2'd0) ? mask_q - 2'd1 : 2'd0;

    owr_e_d = 1'b0;
    if (state_d == ST_PRES) begin
      owr_e_d = 1'b1;
    end else if (state_q == ST_IDLE && state_d == ST_SLOT) begin
      owr_e_d = drive_bit;
    end else if (state_q == ST_SLOT && state_d == ST_SLOT && !sample_now) begin
      owr_e_d = owr_e_q;
    end

    if (state_q == ST_PRES && state_d == ST_IDLE) mask_d = 2'd2;

    if (xfer) begin
      txsh_d  = tx_dat;
      armed_d = 1'b1;
    end

    if (sample_now) begin
      rxsh_d = rx_next;
      bcnt_d = bcnt_q + 3'd1;
      if (armed_q) txsh_d = {1'b0, txsh_q[7:1]};
      if (bcnt_q == 3'd7) begin
        rx_dat_d = rx_next;
        rx_vld_d = 1'b1;
        armed_d  = 1'b0;
      end
    end

    // Partial byte is dropped; rx_dat keeps the last complete byte.
    if (rst_hit) begin
      bus_rst_d = 1'b1;
      bcnt_d    = 3'd0;
      rxsh_d    = 8'h00;
      armed_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      armed_q   <= 1'b0;
      txsh_q    <= 8'h00;
      rxsh_q    <= 8'h00;
      bcnt_q    <= 3'd0;
      rx_dat_q  <= 8'h00;
      rx_vld_q  <= 1'b0;
      bus_rst_q <= 1'b0;
      owr_e_q   <= 1'b0;
      mask_q    <= 2'd0;
    end else begin
      timer_q   <= timer_d;
      armed_q   <= armed_d;
      txsh_q    <= txsh_d;
      rxsh_q    <= rxsh_d;
      bcnt_q    <= bcnt_d;
      rx_dat_q  <= rx_dat_d;
      rx_vld_q  <= rx_vld_d;
      bus_rst_q <= bus_rst_d;
      owr_e_q   <= owr_e_d;
      mask_q    <= mask_d;
    end
  end

  assign owr_e   = owr_e_q;
  assign rx_dat  = rx_dat_q;
  assign rx_vld  = rx_vld_q;
  assign bus_rst = bus_rst_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: a behavioural bus master drives an open-drain line
// model at scaled-down timing; received bytes are checked against a queue.
module tb_onewire_slave;

  localparam int T_SMP    = 30;
  localparam int T_RST    = 400;
  localparam int T_PDLY   = 30;
  localparam int T_PRS    = 120;
  localparam int TW       = 16;
  localparam int SLOT_LEN = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       master_low = 1'b0;
  logic       owr_line;
  logic       owr_e;
  logic [7:0] tx_dat = 8'h00;
  logic       tx_vld = 1'b0;
  logic       tx_rdy;
  logic [7:0] rx_dat;
  logic       rx_vld;
  logic       bus_rst;
  logic [2:0] state_o;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int run_len = 0;
  int last_pulse_len = 0;
  int pulse_start = 0;
  int bus_rst_cnt = 0;
  int bus_rst_cyc = 0;
  int rx_vld_cnt = 0;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];

  assign owr_line = !(master_low || owr_e);

  onewire_slave #(
    .T_SMP (T_SMP),
    .T_RST (T_RST),
    .T_PDLY(T_PDLY),
    .T_PRS (T_PRS),
    .TW    (TW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .owr_i  (owr_line),
    .owr_e  (owr_e),
    .tx_dat (tx_dat),
    .tx_vld (tx_vld),
    .tx_rdy (tx_rdy),
    .rx_dat (rx_dat),
    .rx_vld (rx_vld),
    .bus_rst(bus_rst),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (owr_e) begin
      if (run_len == 0) pulse_start = cyc;
      run_len++;
    end else if (run_len != 0) begin
      last_pulse_len = run_len;
      pulse_cnt++;
      run_len = 0;
    end
    if (bus_rst) begin
      bus_rst_cnt++;
      bus_rst_cyc = cyc;
    end
    if (rst_n && rx_vld) begin
      rx_vld_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_unexpected: got %02h expected no byte", rx_dat);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_dat !== mon_exp) $display("FAIL rx_dat: got %02h expected %02h", rx_dat, mon_exp);
        else pass_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_slot(input logic b);
    int low;
    int gap;
    low = b ? 6 : 60;
    gap = $urandom_range(0, 8);
    @(negedge clk);
    master_low = 1'b1;
    repeat (low) @(negedge clk);
    master_low = 1'b0;
    repeat (SLOT_LEN - low + gap) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) write_slot(b[i]);
  endtask

  task automatic load_tx(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (tx_rdy !== 1'b1) $display("FAIL load_tx_rdy: got %0b expected 1", tx_rdy);
    else pass_cnt++;
    tx_dat = b;
    tx_vld = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
  endtask

  // Eight read slots; a 0-bit must produce one T_SMP-long pulse 3 cycles after the fall.
  task automatic read_slots(input logic [7:0] tx);
    int p0;
    int f;
    int gap;
    exp_q.push_back(tx);
    for (int i = 0; i < 8; i++) begin
      p0 = pulse_cnt;
      gap = $urandom_range(0, 8);
      @(negedge clk);
      master_low = 1'b1;
      f = cyc;
      repeat (6) @(negedge clk);
      master_low = 1'b0;
      repeat (SLOT_LEN - 6 + gap) @(negedge clk);
      chk_cnt++;
      if ((pulse_cnt - p0) != (tx[i] ? 0 : 1))
        $display("FAIL read_slot%0d_pulses: got %0d expected %0d", i, pulse_cnt - p0, tx[i] ? 0 : 1);
      else pass_cnt++;
      if (!tx[i]) begin
        chk_cnt++;
        if (last_pulse_len != T_SMP)
          $display("FAIL read_slot%0d_len: got %0d expected %0d", i, last_pulse_len, T_SMP);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_start - f != 3)
          $display("FAIL read_slot%0d_latency: got %0d expected 3", i, pulse_start - f);
        else pass_cnt++;
      end
    end
  endtask

  task automatic do_bus_reset(output int f, output int r);
    int p0;
    int n;
    p0 = pulse_cnt;
    @(negedge clk);
    master_low = 1'b1;
    f = cyc;
    repeat (500) @(negedge clk);
    master_low = 1'b0;
    r = cyc;
    n = 0;
    while (pulse_cnt == p0 && n < T_PDLY + T_PRS + 100) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (pulse_cnt == p0) $display("FAIL presence_timeout: got %0d pulses expected 1", pulse_cnt - p0);
    else pass_cnt++;
    repeat (10) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (owr_e !== 1'b0) $display("FAIL reset_owr_e: got %0b expected 0", owr_e); else pass_cnt++;
    chk_cnt++;
    if (rx_vld !== 1'b0) $display("FAIL reset_rx_vld: got %0b expected 0", rx_vld); else pass_cnt++;
    chk_cnt++;
    if (rx_dat !== 8'h00) $display("FAIL reset_rx_dat: got %02h expected 00", rx_dat); else pass_cnt++;
    chk_cnt++;
    if (bus_rst !== 1'b0) $display("FAIL reset_bus_rst: got %0b expected 0", bus_rst); else pass_cnt++;
    chk_cnt++;
    if (tx_rdy !== 1'b1) $display("FAIL reset_tx_rdy: got %0b expected 1", tx_rdy); else pass_cnt++;
    chk_cnt++;
    if (state_o !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_o); else pass_cnt++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_bus_reset();
    int b0;
    int v0;
    int f;
    int r;
    b0 = bus_rst_cnt;
    v0 = rx_vld_cnt;
    do_bus_reset(f, r);
    chk_cnt++;
    if (bus_rst_cnt - b0 != 1) $display("FAIL bus_rst_count: got %0d expected 1", bus_rst_cnt - b0); else pass_cnt++;
    chk_cnt++;
    if (bus_rst_cyc - f != T_RST + 3)
      $display("FAIL bus_rst_latency: got %0d expected %0d", bus_rst_cyc - f, T_RST + 3);
    else pass_cnt++;
    // Pin release reaches the synchronized line 2 cycles later.
    chk_cnt++;
    if (pulse_start - r != T_PDLY + 3)
      $display("FAIL presence_start: got %0d expected %0d", pulse_start - r, T_PDLY + 3);
    else pass_cnt++;
    chk_cnt++;
    if (last_pulse_len != T_PRS) $display("FAIL presence_len: got %0d expected %0d", last_pulse_len, T_PRS); else pass_cnt++;
    chk_cnt++;
    if (rx_vld_cnt != v0) $display("FAIL bus_rst_rx_vld: got %0d expected %0d", rx_vld_cnt, v0); else pass_cnt++;
  endtask

  task automatic test_write_byte();
    int p0;
    int v0;
    p0 = pulse_cnt;
    v0 = rx_vld_cnt;
    write_byte(8'hA5);
    chk_cnt++;
    if (rx_vld_cnt - v0 != 1) $display("FAIL write_rx_vld_count: got %0d expected 1", rx_vld_cnt - v0); else pass_cnt++;
    chk_cnt++;
    if (pulse_cnt != p0) $display("FAIL write_owr_e: got %0d pulses expected 0", pulse_cnt - p0); else pass_cnt++;
  endtask

  task automatic test_read_byte();
    load_tx(8'h3C);
    chk_cnt++;
    if (tx_rdy !== 1'b0) $display("FAIL read_tx_rdy_armed: got %0b expected 0", tx_rdy); else pass_cnt++;
    read_slots(8'h3C);
    chk_cnt++;
    if (tx_rdy !== 1'b1) $display("FAIL read_tx_rdy_after: got %0b expected 1", tx_rdy); else pass_cnt++;
  endtask

  task automatic test_random_bytes();
    for (int k = 0; k < 3; k++) write_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic test_partial_reset();
    int v0;
    int f;
    int r;
    write_slot(1'b1);
    write_slot(1'b0);
    write_slot(1'b1);
    write_slot(1'b1);
    v0 = rx_vld_cnt;
    do_bus_reset(f, r);
    chk_cnt++;
    if (rx_vld_cnt != v0) $display("FAIL partial_rx_vld: got %0d expected %0d", rx_vld_cnt, v0); else pass_cnt++;
    write_byte(8'h01);
    chk_cnt++;
    if (rx_vld_cnt - v0 != 1) $display("FAIL partial_next_byte: got %0d strobes expected 1", rx_vld_cnt - v0); else pass_cnt++;
  endtask

  task automatic test_tx_mid_byte();
    int p0;
    int n;
    logic seen;
    logic [7:0] mid_bits;
    mid_bits = 8'h0B;
    p0 = pulse_cnt;
    exp_q.push_back(mid_bits);
    for (int i = 0; i < 3; i++) write_slot(mid_bits[i]);
    tx_dat = 8'hFE;
    tx_vld = 1'b1;
    for (int i = 3; i < 7; i++) begin
      chk_cnt++;
      if (tx_rdy !== 1'b0) $display("FAIL mid_tx_rdy_bit%0d: got %0b expected 0", i, tx_rdy); else pass_cnt++;
      write_slot(mid_bits[i]);
    end
    @(negedge clk);
    master_low = 1'b1;
    repeat (60) @(negedge clk);
    master_low = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (tx_rdy) seen = 1'b1;
      n++;
    end
    chk_cnt++;
    if (seen !== 1'b1) $display("FAIL mid_tx_rdy_return: got %0b expected 1", seen); else pass_cnt++;
    @(negedge clk);
    tx_vld = 1'b0;
    chk_cnt++;
    if (tx_rdy !== 1'b0) $display("FAIL mid_tx_loaded: got %0b expected 0", tx_rdy); else pass_cnt++;
    chk_cnt++;
    if (pulse_cnt != p0) $display("FAIL mid_undriven: got %0d pulses expected 0", pulse_cnt - p0); else pass_cnt++;
    repeat (20) @(negedge clk);
    read_slots(8'hFE);
  endtask

  task automatic test_async_reset();
    int p0;
    int n;
    load_tx(8'h00);
    @(negedge clk);
    master_low = 1'b1;
    n = 0;
    while (!owr_e && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (owr_e !== 1'b1) $display("FAIL arst_drive_before: got %0b expected 1", owr_e); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (owr_e !== 1'b0) $display("FAIL arst_owr_e: got %0b expected 0", owr_e); else pass_cnt++;
    chk_cnt++;
    if (tx_rdy !== 1'b1) $display("FAIL arst_tx_rdy: got %0b expected 1", tx_rdy); else pass_cnt++;
    @(negedge clk);
    master_low = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    p0 = pulse_cnt;
    write_slot(1'b1);
    write_slot(1'b0);
    chk_cnt++;
    if (pulse_cnt != p0) $display("FAIL arst_rx_only: got %0d pulses expected 0", pulse_cnt - p0); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_bus_reset();
    test_write_byte();
    test_read_byte();
    test_random_bytes();
    test_partial_reset();
    test_tx_mid_byte();
    test_async_reset();
    repeat (20) @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d bytes left expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
